// File: rtl/plab4_net_ring_router_bubble_if.sv
// plab4_net_ring_router_bubble_if: ring-stop ports (two credit ring links each way, val/rdy terminal)
// Rev 1.0
`default_nettype none

interface plab4_net_ring_router_bubble_if #(
  parameter int p_msg_nbits = 41
);
  logic                   in0_val;
  logic [p_msg_nbits-1:0] in0_msg;
  logic                   in0_credit;
  logic                   in1_val;
  logic                   in1_rdy;
  logic [p_msg_nbits-1:0] in1_msg;
  logic                   in2_val;
  logic [p_msg_nbits-1:0] in2_msg;
  logic                   in2_credit;
  logic                   out0_val;
  logic [p_msg_nbits-1:0] out0_msg;
  logic                   out0_credit;
  logic                   out1_val;
  logic                   out1_rdy;
  logic [p_msg_nbits-1:0] out1_msg;
  logic                   out2_val;
  logic [p_msg_nbits-1:0] out2_msg;
  logic                   out2_credit;

  modport master (
    output in0_val, in0_msg, in1_val, in1_msg, in2_val, in2_msg,
    output out0_credit, out1_rdy, out2_credit,
    input  in0_credit, in1_rdy, in2_credit,
    input  out0_val, out0_msg, out1_val, out1_msg, out2_val, out2_msg
  );

  modport slave (
    input  in0_val, in0_msg, in1_val, in1_msg, in2_val, in2_msg,
    input  out0_credit, out1_rdy, out2_credit,
    output in0_credit, in1_rdy, in2_credit,
    output out0_val, out0_msg, out1_val, out1_msg, out2_val, out2_msg
  );
endinterface

`default_nettype wire

// File: rtl/plab4_net_ring_router_bubble.sv
// plab4_net_ring_router_bubble: credit-linked bidirectional ring router with bubble injection control
// Rev 1.0
`default_nettype none

module plab4_net_ring_router_bubble #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_queue_depth   = 4
)(
  input  logic                                 clk,
  input  logic                                 reset,
  plab4_net_ring_router_bubble_if.slave        bus
);

  localparam int c_m  = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits;
  localparam int c_s  = p_srcdest_nbits;
  localparam int c_cw = $clog2(p_queue_depth + 1);
  localparam int c_pw = $clog2(p_queue_depth);

  typedef logic [c_cw-1:0] cnt_t;
  typedef logic [c_pw-1:0] ptr_t;
  typedef logic [c_s:0]    dist_t;

  localparam cnt_t  c_depth = cnt_t'(p_queue_depth);
  localparam cnt_t  c_one   = cnt_t'(1);
  localparam cnt_t  c_two   = cnt_t'(2);
  localparam ptr_t  c_last  = ptr_t'(p_queue_depth - 1);
  localparam dist_t c_num   = dist_t'(p_num_routers);
  localparam dist_t c_id    = dist_t'(p_router_id);
  localparam dist_t c_half  = dist_t'(p_num_routers / 2);

  logic [c_m-1:0] r_mem  [3][p_queue_depth];
  ptr_t           r_head [3];
  ptr_t           r_tail [3];
  cnt_t           r_cnt  [3];
  cnt_t           r_cr0, r_cr2;
  logic [1:0]     r_ptr  [3];

  logic [c_m-1:0] w_head    [3];
  logic [c_m-1:0] w_enq_msg [3];
  logic           w_enq_req [3];
  logic           w_enq     [3];
  logic           w_deq     [3];
  logic           w_live    [3];
  logic           w_full    [3];
  dist_t          w_dist    [3];
  logic [1:0]     w_route   [3];
  logic [2:0]     w_req     [3];
  logic           w_fire    [3];
  logic [1:0]     w_win     [3];
  logic [2:0]     w_sum;
  logic [1:0]     w_idx;
  cnt_t           w_cr0_nxt, w_cr2_nxt;

  // Queue heads, route selection and per-output eligibility
  always_comb begin
    w_enq_msg[0] = bus.in0_msg;
    w_enq_msg[1] = bus.in1_msg;
    w_enq_msg[2] = bus.in2_msg;
    w_enq_req[0] = bus.in0_val;
    w_enq_req[1] = bus.in1_val && bus.in1_rdy;
    w_enq_req[2] = bus.in2_val;
    for (int i = 0; i < 3; i++) begin
      w_head[i]  = r_mem[i][r_head[i]];
      w_full[i]  = (r_cnt[i] == c_depth);
      w_live[i]  = reset && (r_cnt[i] != '0);
      w_dist[i]  = {1'b0, w_head[i][c_m-1 -: c_s]} + c_num - c_id;
      if (w_dist[i] >= c_num) w_dist[i] = w_dist[i] - c_num;
      if (w_dist[i] == '0)         w_route[i] = 2'd1;
      else if (w_dist[i] <= c_half) w_route[i] = 2'd2;
      else                          w_route[i] = 2'd0;
      // injection needs two credits so a free slot always remains for transit traffic
      w_req[0][i] = w_live[i] && (w_route[i] == 2'd0) && (r_cr0 >= ((i == 1) ? c_two : c_one));
      w_req[1][i] = w_live[i] && (w_route[i] == 2'd1) && bus.out1_rdy;
      w_req[2][i] = w_live[i] && (w_route[i] == 2'd2) && (r_cr2 >= ((i == 1) ? c_two : c_one));
    end
  end

  // Round-robin search starting at each output's pointer
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    for (int o = 0; o < 3; o++) begin
      w_fire[o] = 1'b0;
      w_win[o]  = 2'd0;
      for (int k = 0; k < 3; k++) begin
        w_sum = {1'b0, r_ptr[o]} + 3'(k);
        if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
        w_idx = w_sum[1:0];
        if (!w_fire[o] && w_req[o][w_idx]) begin
          w_fire[o] = 1'b1;
          w_win[o]  = w_idx;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_deq[i] = (w_fire[0] && (w_win[0] == 2'(i))) ||
                 (w_fire[1] && (w_win[1] == 2'(i))) ||
                 (w_fire[2] && (w_win[2] == 2'(i)));
      // a full queue that drains this cycle can still take a word at the edge
      w_enq[i] = reset && w_enq_req[i] && (!w_full[i] || w_deq[i]);
    end
    w_cr0_nxt = r_cr0;
    if (w_fire[0] && !bus.out0_credit)                             w_cr0_nxt = r_cr0 - c_one;
    else if (!w_fire[0] && bus.out0_credit && (r_cr0 != c_depth)) w_cr0_nxt = r_cr0 + c_one;
    w_cr2_nxt = r_cr2;
    if (w_fire[2] && !bus.out2_credit)                             w_cr2_nxt = r_cr2 - c_one;
    else if (!w_fire[2] && bus.out2_credit && (r_cr2 != c_depth)) w_cr2_nxt = r_cr2 + c_one;
  end

  assign bus.out0_val   = w_fire[0];
  assign bus.out0_msg   = w_head[w_win[0]];
  assign bus.out1_val   = w_fire[1];
  assign bus.out1_msg   = w_head[w_win[1]];
  assign bus.out2_val   = w_fire[2];
  assign bus.out2_msg   = w_head[w_win[2]];
  assign bus.in0_credit = w_deq[0];
  assign bus.in2_credit = w_deq[2];
  assign bus.in1_rdy    = reset && !w_full[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
        r_cnt[i]  <= '0;
        r_ptr[i]  <= 2'd0;
      end
      r_cr0 <= c_depth;
      r_cr2 <= c_depth;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_enq[i]) begin
          r_mem[i][r_tail[i]] <= w_enq_msg[i];
          r_tail[i] <= (r_tail[i] == c_last) ? '0 : r_tail[i] + 1'b1;
        end
        if (w_deq[i]) r_head[i] <= (r_head[i] == c_last) ? '0 : r_head[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + cnt_t'(w_enq[i]) - cnt_t'(w_deq[i]);
        if (w_fire[i]) r_ptr[i] <= (w_win[i] == 2'd2) ? 2'd0 : w_win[i] + 2'd1;
      end
      r_cr0 <= w_cr0_nxt;
      r_cr2 <= w_cr2_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(bus.in0_val && w_full[0] && !w_deq[0])) else $error("in0 arrived at full queue; message dropped");
      assert (!(bus.in2_val && w_full[2] && !w_deq[2])) else $error("in2 arrived at full queue; message dropped");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_plab4_net_ring_router_bubble.sv
// tb_plab4_net_ring_router_bubble: random traffic against a queue-level reference of the router
// Rev 1.0
`default_nettype none

module tb_plab4_net_ring_router_bubble;

  localparam int P = 32;
  localparam int O = 3;
  localparam int S = 3;
  localparam int ID = 2;
  localparam int N = 8;
  localparam int D = 4;
  localparam int M = P + O + 2*S;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab4_net_ring_router_bubble_if #(.p_msg_nbits(M)) bus ();

  plab4_net_ring_router_bubble #(
    .p_payload_nbits (P),
    .p_opaque_nbits  (O),
    .p_srcdest_nbits (S),
    .p_router_id     (ID),
    .p_num_routers   (N),
    .p_queue_depth   (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: plain FIFOs, integer credit counts, round-robin pointers
  logic [M-1:0] mq0[$], mq1[$], mq2[$];
  int m_cr[3];
  int m_ptr[3];
  int e_fire[3], e_win[3], e_deq[3];
  logic [M-1:0] e_msg[3];

  function automatic int qsize(int i);
    case (i)
      0: return mq0.size();
      1: return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  function automatic logic [M-1:0] qhead(int i);
    case (i)
      0: return mq0[0];
      1: return mq1[0];
      default: return mq2[0];
    endcase
  endfunction

  function automatic int route_of(logic [M-1:0] msg);
    int dest, d;
    dest = int'(msg[M-1 -: S]);
    if (dest == ID) return 1;
    d = (dest - ID + N) % N;
    return (d <= N/2) ? 2 : 0;
  endfunction

  function automatic bit eligible(int o, int i);
    if (o == 1) return bus.out1_rdy;
    return m_cr[o] >= ((i == 1) ? 2 : 1);
  endfunction

  task automatic model_eval();
    int i;
    for (int o = 0; o < 3; o++) begin
      e_fire[o] = 0; e_win[o] = 0; e_deq[o] = 0; e_msg[o] = '0;
    end
    if (!reset) return;
    for (int o = 0; o < 3; o++) begin
      for (int k = 0; k < 3; k++) begin
        i = (m_ptr[o] + k) % 3;
        if (e_fire[o] == 0 && qsize(i) > 0 && route_of(qhead(i)) == o && eligible(o, i)) begin
          e_fire[o] = 1;
          e_win[o]  = i;
          e_msg[o]  = qhead(i);
        end
      end
    end
    for (int o = 0; o < 3; o++) if (e_fire[o] != 0) e_deq[e_win[o]] = 1;
  endtask

  task automatic model_update();
    int sz1;
    if (!reset) begin
      mq0.delete(); mq1.delete(); mq2.delete();
      for (int o = 0; o < 3; o++) begin m_cr[o] = D; m_ptr[o] = 0; end
      return;
    end
    sz1 = mq1.size();
    if (e_deq[0] != 0) void'(mq0.pop_front());
    if (e_deq[1] != 0) void'(mq1.pop_front());
    if (e_deq[2] != 0) void'(mq2.pop_front());
    for (int o = 0; o < 3; o++) if (e_fire[o] != 0) m_ptr[o] = (e_win[o] + 1) % 3;
    m_cr[0] = m_cr[0] - e_fire[0] + int'(bus.out0_credit);
    m_cr[2] = m_cr[2] - e_fire[2] + int'(bus.out2_credit);
    if (m_cr[0] > D) m_cr[0] = D;
    if (m_cr[2] > D) m_cr[2] = D;
    if (bus.in0_val) mq0.push_back(bus.in0_msg);
    if (bus.in1_val && sz1 < D) mq1.push_back(bus.in1_msg);
    if (bus.in2_val) mq2.push_back(bus.in2_msg);
  endtask

  function automatic logic [M-1:0] rand_msg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[M-1:0];
  endfunction

  int p_val, p_rdy, p_cr;

  initial begin
    bus.in0_val = 1'b0; bus.in0_msg = '0;
    bus.in1_val = 1'b0; bus.in1_msg = '0;
    bus.in2_val = 1'b0; bus.in2_msg = '0;
    bus.out0_credit = 1'b0; bus.out1_rdy = 1'b0; bus.out2_credit = 1'b0;
    for (int o = 0; o < 3; o++) begin m_cr[o] = D; m_ptr[o] = 0; end
    p_val = 50; p_rdy = 50; p_cr = 50;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc % 250 == 0) begin
        p_val = int'($urandom_range(20, 95));
        p_rdy = int'($urandom_range(0, 100));
        p_cr  = int'($urandom_range(0, 90));
      end
      reset = (cyc < 3) ? 1'b0 : (($urandom % 300) != 0);
      bus.out1_rdy    = ($urandom % 100) < p_rdy;
      bus.out0_credit = ($urandom % 100) < p_cr;
      bus.out2_credit = ($urandom % 100) < p_cr;
      model_eval();
      // ring senders only transmit when a slot is free or is being freed this cycle
      bus.in0_val = (($urandom % 100) < p_val) && (mq0.size() < D || e_deq[0] != 0);
      bus.in2_val = (($urandom % 100) < p_val) && (mq2.size() < D || e_deq[2] != 0);
      bus.in1_val = ($urandom % 100) < p_val;
      bus.in0_msg = rand_msg();
      bus.in1_msg = rand_msg();
      bus.in2_msg = rand_msg();
      #1;
      check("in1_rdy",    64'(bus.in1_rdy),    64'(reset && mq1.size() < D));
      check("in0_credit", 64'(bus.in0_credit), 64'(e_deq[0]));
      check("in2_credit", 64'(bus.in2_credit), 64'(e_deq[2]));
      check("out0_val",   64'(bus.out0_val),   64'(e_fire[0]));
      check("out1_val",   64'(bus.out1_val),   64'(e_fire[1]));
      check("out2_val",   64'(bus.out2_val),   64'(e_fire[2]));
      if (e_fire[0] != 0) check("out0_msg", 64'(bus.out0_msg), 64'(e_msg[0]));
      if (e_fire[1] != 0) check("out1_msg", 64'(bus.out1_msg), 64'(e_msg[1]));
      if (e_fire[2] != 0) check("out2_msg", 64'(bus.out2_msg), 64'(e_msg[2]));
      model_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/plab4_net_ring_router_bubble.md
# plab4_net_ring_router_bubble

Parametrised bidirectional ring router, the next-generation tile router for the ring network. It replaces val/rdy ring channels with credit-based ring links and adds per-router input buffering of configurable depth. It routes each message on the shortest path and uses bubble flow control so that injection can never deadlock the ring. One instance sits at each ring stop, with its terminal port connected to a core or cache.

## Interface
Parameters:
- p_payload_nbits, 32, payload width
- p_opaque_nbits, 3, opaque field width
- p_srcdest_nbits, 3, src/dest id width
- p_router_id, 0, this router's id (0..p_num_routers-1)
- p_num_routers, 8, routers on ring (2..2^p_srcdest_nbits)
- p_queue_depth, 4, entries per input queue; must be ≥2
- Derived: m = payload+opaque+2*srcdest; message layout {dest, src, opaque, payload}, dest in MSBs; cw = clog2(p_queue_depth+1)

Ports:
- clk  in  1  clock; everything is on posedge
- reset  in  1  synchronous, active-low: reset==0 at a posedge resets the block
- in0_val  in  1  forward ring input, from router id-1
- in0_msg  in  m  forward ring message
- in0_credit  out  1  one-cycle pulse: one in0 queue entry freed
- in1_val/in1_rdy/in1_msg  in/out/in  1/1/m  terminal injection, val/rdy handshake
- in2_val  in  1  backward ring input, from router id+1
- in2_msg  in  m  backward ring message
- in2_credit  out  1  one-cycle pulse: one in2 queue entry freed
- out0_val/out0_msg  out  1/m  backward ring output, to router id-1
- out0_credit  in  1  credit return from router id-1
- out1_val/out1_rdy/out1_msg  out/in/out  1/1/m  terminal ejection, val/rdy handshake
- out2_val/out2_msg  out  1/m  forward ring output, to router id+1
- out2_credit  in  1  credit return from router id+1

## Operation
- Buffering: three FIFO input queues (q0, q1, q2), each p_queue_depth deep.
  - in0_val / in2_val enqueue unconditionally; the sender guarantees space via credits.
  - in1 enqueues on in1_val && in1_rdy, with in1_rdy = !q1_full.
- Route computation on each non-empty queue head:
  - dest == p_router_id → out1.
  - Otherwise d = (dest − p_router_id + p_num_routers) mod p_num_routers, computed in s+1 bits.
  - d ≤ p_num_routers/2 (integer divide) → out2 (forward); else → out0 (backward). The tie at exactly N/2 goes forward.
- Credit counters:
  - cr0 and cr2 (cw bits) track free slots in the downstream queues. Reset value is p_queue_depth.
  - Decrement on send, increment on credit pulse; both in the same cycle → unchanged.
- Eligibility:
  - Transit head (from q0 or q2) to a ring output: needs cr ≥ 1.
  - Injection head (from q1) to a ring output: needs cr ≥ 2. This is the bubble rule.
  - Any head to out1: needs out1_rdy.
- Arbitration: one round-robin arbiter per output over the eligible requesters {q0, q1, q2}.
  - Each pointer resets to q0.
  - After a grant that fires, the pointer moves to the input after the winner. It does not move when nothing fires.
  - Each head requests exactly one output, so no input is ever granted twice.
- Firing:
  - A grant dequeues the winning head and drives outX_val=1 with outX_msg equal to that head in the same cycle.
  - On out1 the grant requires out1_rdy.
  - A dequeue from q0 pulses in0_credit=1 in that cycle; a dequeue from q2 pulses in2_credit=1.
- Message contents pass through unmodified.

## Timing
- Reset (reset==0 at a posedge):
  - Queues empty, cr0 = cr2 = p_queue_depth, pointers at q0.
  - While reset==0: out0_val, out1_val, out2_val, in0_credit, in2_credit and in1_rdy are all 0.
- Reset mid-operation discards all buffered messages; the next-cycle outputs are as after reset.
- Latency:
  - An input accepted at edge t is at the queue head in cycle t+1 and can leave in cycle t+1.
  - Minimum traversal is therefore 1 cycle.
  - Queue throughput is 1 msg/cycle per queue.
- Full-queue bypass: a full queue that dequeues in cycle t may accept an enqueue at edge t. in1_rdy still reflects start-of-cycle fullness.
- Protocol violations: in0_val/in2_val arriving at a full queue is a sender violation. The message is dropped and a simulation $display error is raised.
- Simultaneous send and credit return with cr == 0: result is cr == 0, and the send is illegal because it is not eligible.
- Credit counters never exceed p_queue_depth.

## Test plan
- Loopback (id=3, N=8): in1 msg with dest=3 → out1_val in the next cycle with the identical msg; in1_rdy stays 1.
- Routing (id=0, N=8):
  - dest=4 → out2 (tie goes forward).
  - dest=5 → out0.
  - dest=1 → out2.
  - in0 msg with dest=0 → out1, with in0_credit pulsing in the same cycle.
- Bubble (depth=4): hold out2_credit=0 and drain cr2 to 1 with forward transit messages.
  - A further in0 transit message still sends (cr2 → 0).
  - A forward-bound in1 head stalls.
  - Pulse out2_credit twice → injection fires once cr2 reaches 2.
- Arbitration: q0, q1 and q2 all hold heads for out1 with out1_rdy=1 → grants in order q0, q1, q2, q0.
  - With out1_rdy=0 for 3 cycles the order is preserved and no credits pulse.
- Credit edge: send on out0 in the same cycle out0_credit=1 → cr0 unchanged. Fill q1 to depth → in1_rdy=0.
- Reset: drop reset to 0 with all queues non-empty → all vals, credits and in1_rdy are 0.
  - After release, cr0 = cr2 = 4 and no stale messages emerge.
